maxnet_input_loader: RTL and testbench
======================================

// Module: maxnet_input_loader
// PURPOSE
//  Upstream feeder for the Maxnet datapath. Accepts one frame over a valid/ready
//  stream: epsilon, then a1..a4 (32-bit IEEE-754 single).
//  Sanity-checks the frame, then holds a1_init..a4_init/epsilon stable and pulses start.
//  Waits for the datapath's finish, captures its winner output, and presents it downstream.
// PARAMETERS
//  DATA_W    32    word width; fixed to fp32, other values unsupported
//  TIMEOUT   1024  max cycles in BUSY before abort
// PORTS
//  clk           in   1       sole clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  in_valid      in   1       word on in_data valid
//  in_ready      out  1       loader accepts word this cycle
//  in_data       in   DATA_W  frame word (order: eps, a1, a2, a3, a4)
//  a1_init..a4_init out DATA_W  activations to datapath, stable from start to finish
//  epsilon       out  DATA_W  inhibition weight to datapath
//  start         out  1       one-cycle launch pulse to datapath
//  finish        in   1       datapath done; out is valid in the same cycle
//  dp_out        in   DATA_W  datapath result
//  result        out  DATA_W  captured result
//  result_valid  out  1       result held until result_ready
//  result_ready  in   1       consumer takes result
//  err_eps       out  1       1-cycle pulse: frame rejected, bad epsilon
//  err_timeout   out  1       1-cycle pulse: BUSY exceeded TIMEOUT
//  neg_clamped   out  1       high with start if any activation was clamped
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; state LOAD; word count 0.
//  States:
//   - LOAD: in_ready = !result_valid. On each in_valid&&in_ready, store the word at index cnt and increment cnt.
//     Activation words with sign=1 are stored as +0.0 (32'h0) and set the clamp flag.
//     The handshake with cnt==4 goes to CHECK.
//   - CHECK (1 cycle, in_ready=0): the epsilon word is bad if sign=1, or the value is 0, or exp>=125 (eps>=0.25).
//     Bad: err_eps=1, cnt=0, clamp flag cleared, back to LOAD with no start.
//     Good: go to LAUNCH.
//   - LAUNCH (1 cycle): start=1, neg_clamped=clamp flag; go to BUSY, timer=0.
//   - BUSY: timer increments each cycle.
//     On finish: result<=dp_out, result_valid<=1, go to LOAD with cnt=0.
//     If timer reaches TIMEOUT-1 without finish: err_timeout=1, go to LOAD, no result.
//  Edge cases:
//   - finish outside BUSY is ignored.
//   - result_valid clears on result_ready. A handshake in LOAD therefore requires the result to have been consumed.
//   - a1_init..a4_init and epsilon change only on LOAD handshakes; they are never written in CHECK/LAUNCH/BUSY.
//   - rst mid-frame or mid-BUSY returns immediately to reset values; partial frames are discarded.
//  Latency: last-word handshake -> start = 2 cycles; finish -> result_valid = 1 cycle.
// STRUCTURE
//  Shared package maxnet_pkg:
//   - state encoding LOAD/CHECK/LAUNCH/BUSY
//   - FP32 field positions
//   - EPS_EXP_MAX=8'd125
//   - FRAME_WORDS=5
//  One combinational sub-module maxnet_fp_check: takes a word and outputs is_neg, is_zero, and eps_too_big.
//  It is instantiated once on in_data for clamp detection and once on the stored epsilon.
// TESTING
//  - Frame 3DCCCCCD,3F000000,3F4CCCCD,3E99999A,3F666666 -> start pulses 2 cycles after the last word.
//    Outputs held; finish with dp_out=3F666666 -> result=3F666666, result_valid=1.
//  - Epsilon 3E800000 (0.25) -> err_eps pulse, no start, next frame accepted normally.
//  - Activation BE4CCCCD (-0.2) -> that a_init=0, neg_clamped=1 during start.
//  - No finish after start -> err_timeout after TIMEOUT cycles, state LOAD, result_valid stays 0.
//  - result_ready held 0 after a result -> in_ready=0.
//    Raise result_ready -> valid drops and in_ready returns the next cycle.
//  - rst asserted after 3 words, and again during BUSY -> all outputs 0 immediately.
//    A fresh 5-word frame then launches correctly.

Source files
------------

// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared state encoding, fp32 field positions and frame constants for the Maxnet loader
package maxnet_pkg;
    typedef enum logic [1:0] {LOAD, CHECK, LAUNCH, BUSY} state_t;
    localparam int FP_SIGN = 31;
    localparam int FP_EXP_MSB = 30;
    localparam int FP_EXP_LSB = 23;
    localparam logic [7:0] EPS_EXP_MAX = 8'd125;
    localparam int FRAME_WORDS = 5;
endpackage

// File: rtl/maxnet_fp_check.sv
// maxnet_fp_check: classifies an fp32 word as negative, zero (either sign) or >= 0.25
// Ports: word_i fp32 word in; is_neg_o sign bit; is_zero_o +/-0.0; eps_too_big_o exponent >= 125
module maxnet_fp_check
    import maxnet_pkg::*;
(
    input  logic [31:0] word_i,
    output logic        is_neg_o,
    output logic        is_zero_o,
    output logic        eps_too_big_o
);
    assign is_neg_o      = word_i[FP_SIGN];
    assign is_zero_o     = word_i[FP_EXP_MSB:0] == '0;
    assign eps_too_big_o = word_i[FP_EXP_MSB:FP_EXP_LSB] >= EPS_EXP_MAX;
endmodule

// File: rtl/maxnet_input_loader.sv
// maxnet_input_loader: loads an eps/a1..a4 frame, vets epsilon, launches the Maxnet datapath and returns its winner
// Ports: in_valid/in_ready/in_data frame stream; a1_init..a4_init/epsilon/start datapath launch;
//        finish/dp_out datapath completion; result/result_valid/result_ready downstream result;
//        err_eps/err_timeout error pulses; neg_clamped flags clamped activations during start
module maxnet_input_loader
    import maxnet_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] a1_init,
    output logic [DATA_W-1:0] a2_init,
    output logic [DATA_W-1:0] a3_init,
    output logic [DATA_W-1:0] a4_init,
    output logic [DATA_W-1:0] epsilon,
    output logic              start,
    input  logic              finish,
    input  logic [DATA_W-1:0] dp_out,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              err_eps,
    output logic              err_timeout,
    output logic              neg_clamped
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] LAST = 3'(FRAME_WORDS - 1);

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [DATA_W-1:0]      eps_q, eps_d, result_q, result_d;
    logic [3:0][DATA_W-1:0] a_q, a_d;
    logic                   clamp_q, clamp_d, rv_q, rv_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [1:0]             a_idx;
    logic                   hs, in_neg, unused_in_zero, unused_in_big;
    logic                   eps_neg, eps_zero, eps_big, eps_bad, timed_out;

    maxnet_fp_check u_in_check (
        .word_i        (in_data),
        .is_neg_o      (in_neg),
        .is_zero_o     (unused_in_zero),
        .eps_too_big_o (unused_in_big)
    );

    maxnet_fp_check u_eps_check (
        .word_i        (eps_q),
        .is_neg_o      (eps_neg),
        .is_zero_o     (eps_zero),
        .eps_too_big_o (eps_big)
    );

    // in_ready is gated by rst so every output reads 0 while reset is held
    assign in_ready  = state_q == LOAD && !rv_q && !rst;
    assign hs        = in_valid && in_ready;
    assign eps_bad   = eps_neg || eps_zero || eps_big;
    assign timed_out = state_q == BUSY && !finish && timer_q == TW'(TIMEOUT - 1);
    assign a_idx     = 2'(cnt_q - 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    state_d = (hs && cnt_q == LAST) ? CHECK : LOAD;
            CHECK:   state_d = eps_bad ? LOAD : LAUNCH;
            LAUNCH:  state_d = BUSY;
            BUSY:    state_d = (finish || timed_out) ? LOAD : BUSY;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        eps_d    = eps_q;
        a_d      = a_q;
        clamp_d  = clamp_q;
        result_d = result_q;
        timer_d  = timer_q + 1'b1;
        rv_d     = rv_q && !result_ready;
        if (hs) begin
            // the count wraps on the last word, so every exit back to LOAD already sees cnt 0
            cnt_d = (cnt_q == LAST) ? 3'd0 : cnt_q + 3'd1;
            if (cnt_q == 3'd0) begin
                eps_d = in_data;
            end else begin
                a_d[a_idx] = in_neg ? '0 : in_data;
                clamp_d    = clamp_q || in_neg;
            end
        end
        if (state_q == CHECK && eps_bad) clamp_d = 1'b0;
        if (state_q == LAUNCH) begin
            clamp_d = 1'b0;
            timer_d = '0;
        end
        if (state_q == BUSY && finish) begin
            result_d = dp_out;
            rv_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            eps_q    <= '0;
            a_q      <= '0;
            clamp_q  <= 1'b0;
            result_q <= '0;
            rv_q     <= 1'b0;
            timer_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            eps_q    <= eps_d;
            a_q      <= a_d;
            clamp_q  <= clamp_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        start        = state_q == LAUNCH;
        neg_clamped  = state_q == LAUNCH && clamp_q;
        err_eps      = state_q == CHECK && eps_bad;
        err_timeout  = timed_out;
        a1_init      = a_q[0];
        a2_init      = a_q[1];
        a3_init      = a_q[2];
        a4_init      = a_q[3];
        epsilon      = eps_q;
        result       = result_q;
        result_valid = rv_q;
    end
endmodule

// File: tb/tb_maxnet_input_loader.sv
// tb_maxnet_input_loader: directed frame table plus timeout, backpressure and reset sequences
module tb_maxnet_input_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [31:0] a1_init, a2_init, a3_init, a4_init, epsilon;
    logic        start;
    logic        finish = 1'b0;
    logic [31:0] dp_out = '0;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic        err_eps, err_timeout, neg_clamped;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    maxnet_input_loader dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .a1_init      (a1_init),
        .a2_init      (a2_init),
        .a3_init      (a3_init),
        .a4_init      (a4_init),
        .epsilon      (epsilon),
        .start        (start),
        .finish       (finish),
        .dp_out       (dp_out),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .err_eps      (err_eps),
        .err_timeout  (err_timeout),
        .neg_clamped  (neg_clamped)
    );

    typedef struct packed {
        logic [4:0][31:0] w;
        logic [3:0][31:0] a_exp;
        logic [31:0]      dp;
        logic             bad;
        logic             clamp;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input logic [31:0] e, w1, w2, w3, w4, x1, x2, x3, x4, d,
                                input logic bad, clamp);
        vec_t v;
        v.w     = {w4, w3, w2, w1, e};
        v.a_exp = {x4, x3, x2, x1};
        v.dp    = d;
        v.bad   = bad;
        v.clamp = clamp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_in_ready"}, in_ready, 0);
        chk({name, "_words"}, a1_init | a2_init | a3_init | a4_init | epsilon | result, 0);
        chk({name, "_flags"}, {start, result_valid, err_eps, err_timeout, neg_clamped}, 0);
    endtask

    task automatic send(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        #1;
        chk("word_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        for (int i = 0; i < 5; i++) send(v.w[i]);
        chk("check_err_eps", err_eps, 32'(v.bad));
        chk("check_no_start", start, 0);
        chk("check_in_ready", in_ready, 0);
        tick();
        if (v.bad) begin
            chk("bad_no_start", start, 0);
            chk("bad_err_clear", err_eps, 0);
            chk("bad_in_ready", in_ready, 1);
        end else begin
            chk("launch_start", start, 1);
            chk("launch_clamp", neg_clamped, 32'(v.clamp));
            chk("launch_eps", epsilon, v.w[0]);
            chk("launch_a1", a1_init, v.a_exp[0]);
            chk("launch_a2", a2_init, v.a_exp[1]);
            chk("launch_a3", a3_init, v.a_exp[2]);
            chk("launch_a4", a4_init, v.a_exp[3]);
            tick();
            chk("busy_start_low", start, 0);
            repeat (3) tick();
            chk("busy_a_held", {a1_init, a2_init, a3_init, a4_init}, {v.a_exp[0], v.a_exp[1], v.a_exp[2], v.a_exp[3]});
            chk("busy_eps_held", epsilon, v.w[0]);
            chk("busy_in_ready", in_ready, 0);
            finish = 1'b1;
            dp_out = v.dp;
            #1;
            chk("finish_rv_not_yet", result_valid, 0);
            tick();
            finish = 1'b0;
            dp_out = 32'hDEADBEEF;
            chk("result_valid", result_valid, 1);
            chk("result_value", result, v.dp);
            chk("held_in_ready", in_ready, 0);
            in_valid = 1'b1;
            in_data  = 32'h3F000000;
            tick();
            chk("held_rv", result_valid, 1);
            chk("held_in_ready2", in_ready, 0);
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
            in_valid = 1'b0;
            chk("consumed_rv", result_valid, 0);
            chk("consumed_in_ready", in_ready, 1);
        end
    endtask

    initial begin
        int n;
        vecs[0] = mk(32'h3DCCCCCD, 32'h3F000000, 32'h3F4CCCCD, 32'h3E99999A, 32'h3F666666,
                     32'h3F000000, 32'h3F4CCCCD, 32'h3E99999A, 32'h3F666666, 32'h3F666666, 1'b0, 1'b0);
        vecs[1] = mk(32'h3E800000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        vecs[2] = mk(32'h3E4CCCCD, 32'h3F000000, 32'hBE4CCCCD, 32'h3F800000, 32'h3E000000,
                     32'h3F000000, 32'h00000000, 32'h3F800000, 32'h3E000000, 32'h3F800000, 1'b0, 1'b1);
        vecs[3] = mk(32'h00000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        vecs[4] = mk(32'hBDCCCCCD, 32'hBF000000, 32'h3F000000, 32'h3F000000, 32'h3F000000,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        vecs[5] = mk(32'h3E7FFFFF, 32'h3E000000, 32'h3E800000, 32'h3F000000, 32'h3F400000,
                     32'h3E000000, 32'h3E800000, 32'h3F000000, 32'h3F400000, 32'h3E7FFFFF, 1'b0, 1'b0);

        #2;
        chk_all_zero("reset_hold");
        tick();
        rst = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);
        finish = 1'b1;
        dp_out = 32'h12345678;
        tick();
        finish = 1'b0;
        chk("idle_finish_ignored", result_valid, 0);
        chk("idle_state_load", in_ready, 1);

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        for (int i = 0; i < 5; i++) send(vecs[0].w[i]);
        tick();
        chk("to_launch_start", start, 1);
        tick();
        n = 0;
        while (!err_timeout && n < 2000) begin
            tick();
            n++;
        end
        chk("timeout_cycle", n, 1023);
        tick();
        chk("timeout_pulse_len", err_timeout, 0);
        chk("timeout_rv", result_valid, 0);
        chk("timeout_in_ready", in_ready, 1);

        for (int i = 0; i < 3; i++) send(vecs[2].w[i]);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid_frame");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) send(vecs[5].w[i]);
        repeat (4) tick();
        chk("pre_rst_busy", in_ready, 0);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid_busy");
        tick();
        rst = 1'b0;
        run_frame(vecs[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
